// File: rtl/i2c_xfer_counter.sv
// i2c_xfer_counter: two-level bit/frame counter with done pulses for the I2C master FSM
module i2c_xfer_counter #(
    parameter int BITS_PER_FRAME = 9,
    parameter int BIT_W          = 4,
    parameter int LEN_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [LEN_W-1:0] len_in,
    input  logic             bit_inc,
    output logic [BIT_W-1:0] bit_cnt,
    output logic [LEN_W-1:0] byte_cnt,
    output logic             ack_slot,
    output logic             last_byte,
    output logic             frame_done,
    output logic             xfer_done,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    localparam logic [BIT_W-1:0] LAST = BIT_W'(BITS_PER_FRAME - 1);
    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] byte_nxt;
    assign byte_nxt  = byte_cnt + 1'b1;
    assign ack_slot  = (state == RUN) && (bit_cnt == LAST);
    assign last_byte = (state == RUN) && (byte_cnt == len - 1'b1);
    // Control state, counters and pulses; priority clr > load > bit_inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
            xfer_done  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            xfer_done  <= 1'b0;
            if (clr) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                busy     <= 1'b0;
                err      <= 1'b0;
            end else if (load) begin
                len       <= len_in;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                err       <= 1'b0;
                state     <= (len_in != '0) ? RUN : HALT;
                busy      <= (len_in != '0);
                xfer_done <= (len_in == '0);
            end else if (bit_inc) begin
                if (state != RUN) begin
                    err <= 1'b1;
                end else if (bit_cnt < LAST) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    bit_cnt    <= '0;
                    byte_cnt   <= byte_nxt;
                    frame_done <= 1'b1;
                    if (byte_nxt == len) begin
                        xfer_done <= 1'b1;
                        state     <= HALT;
                        busy      <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_xfer_counter.sv
// tb_i2c_xfer_counter: table-driven scoreboard bench for i2c_xfer_counter
module tb_i2c_xfer_counter;
    typedef struct packed {
        logic       clr;
        logic       load;
        logic [7:0] len_in;
        logic       inc;
        logic [3:0] bc;
        logic [7:0] yc;
        logic       ack;
        logic       last;
        logic       fd;
        logic       xd;
        logic       busy;
        logic       err;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, load = 1'b0, bit_inc = 1'b0;
    logic [7:0] len_in = '0;
    logic [3:0] bc1;
    logic [7:0] yc1;
    logic ack1, last1, fd1, xd1, busy1, err1;
    logic [0:0] bc2;
    logic [1:0] yc2;
    logic ack2, last2, fd2, xd2, busy2, err2;
    logic chk2 = 1'b0;
    int n_cmp = 0, n_bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    i2c_xfer_counter dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .len_in(len_in), .bit_inc(bit_inc),
        .bit_cnt(bc1), .byte_cnt(yc1), .ack_slot(ack1), .last_byte(last1),
        .frame_done(fd1), .xfer_done(xd1), .busy(busy1), .err(err1)
    );

    i2c_xfer_counter #(.BITS_PER_FRAME(2), .BIT_W(1), .LEN_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .len_in(len_in[1:0]), .bit_inc(bit_inc),
        .bit_cnt(bc2), .byte_cnt(yc2), .ack_slot(ack2), .last_byte(last2),
        .frame_done(fd2), .xfer_done(xd2), .busy(busy2), .err(err2)
    );

    function automatic logic [17:0] actual();
        return chk2 ? {3'b0, bc2, 6'b0, yc2, ack2, last2, fd2, xd2, busy2, err2}
                    : {bc1, yc1, ack1, last1, fd1, xd1, busy1, err1};
    endfunction

    function automatic logic [17:0] outs(input vec_t v);
        return {v.bc, v.yc, v.ack, v.last, v.fd, v.xd, v.busy, v.err};
    endfunction

    // Expected outputs after the k-th bit_inc of a transfer of L frames
    function automatic vec_t rv(input int L, input int bpf, input int k);
        vec_t v = '0;
        v.inc  = 1'b1;
        v.bc   = 4'(k % bpf);
        v.yc   = 8'(k / bpf);
        v.busy = k < L * bpf;
        v.ack  = v.busy && (k % bpf == bpf - 1);
        v.last = v.busy && (k / bpf == L - 1);
        v.fd   = (k > 0) && (k % bpf == 0);
        v.xd   = (k == L * bpf);
        return v;
    endfunction

    function automatic vec_t ld(input int L);
        vec_t v = '0;
        v.load   = 1'b1;
        v.len_in = 8'(L);
        v.busy   = L != 0;
        v.xd     = L == 0;
        v.last   = L == 1;
        return v;
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        vec_t e;
        clr     = v.clr;
        load    = v.load;
        len_in  = v.len_in;
        bit_inc = v.inc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("step%0d", n_cmp), actual(), outs(e));
        clr     = 1'b0;
        load    = 1'b0;
        bit_inc = 1'b0;
    endtask

    initial begin
        vec_t v;
        #1;
        check("reset", actual(), '0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(ld(2));
        for (int k = 1; k <= 18; k++) tbl.push_back(rv(2, 9, k));
        tbl.push_back(ld(3));
        for (int k = 1; k <= 27; k++) tbl.push_back(rv(3, 9, k));
        tbl.push_back(ld(0));
        v = '0; v.inc = 1'b1; v.err = 1'b1;
        tbl.push_back(v);
        v.inc = 1'b0;
        tbl.push_back(v);
        tbl.push_back(ld(1));
        for (int k = 1; k <= 5; k++) tbl.push_back(rv(1, 9, k));
        v = '0; v.clr = 1'b1; v.load = 1'b1; v.len_in = 8'd5;
        tbl.push_back(v);
        tbl.push_back(ld(1));
        for (int k = 1; k <= 9; k++) tbl.push_back(rv(1, 9, k));
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        drive(ld(3));
        for (int k = 1; k <= 13; k++) drive(rv(3, 9, k));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", actual(), '0);
        @(negedge clk);
        rst = 1'b0;
        v = '0; v.inc = 1'b1; v.err = 1'b1;
        drive(v);

        chk2 = 1'b1;
        drive(ld(3));
        for (int k = 1; k <= 6; k++) drive(rv(3, 2, k));
        v = '0; v.inc = 1'b1; v.yc = 8'd3; v.err = 1'b1;
        drive(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_xfer_counter.md
# i2c_xfer_counter

Parametrised two-level bit/byte counter for the I2C master FSM, replacing the fixed 4-bit clear/increment counter. It counts bits within a frame (data bits plus ACK slot) and frames within a transfer of programmable length. It raises per-frame and end-of-transfer pulses, and flags increments issued while no transfer is armed. The master FSM drives `bit_inc` once per SCL bit and uses the flags to branch between data, ACK and STOP phases.

## Interface
- `BITS_PER_FRAME`, default 9: bits per frame (8 data + 1 ACK); legal range 2..2^BIT_W.
- `BIT_W`, default 4: width of `bit_cnt`.
- `LEN_W`, default 8: width of transfer length and `byte_cnt`.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear of counters, state and error.
- `load`  in  1  arm a new transfer with length `len_in`.
- `len_in`  in  LEN_W  number of frames in the transfer; sampled only when `load`=1.
- `bit_inc`  in  1  one bit period elapsed.
- `bit_cnt`  out  BIT_W  bit index within the current frame, 0..BITS_PER_FRAME-1.
- `byte_cnt`  out  LEN_W  frames completed in the current transfer.
- `ack_slot`  out  1  `bit_cnt` == BITS_PER_FRAME-1 while in RUN.
- `last_byte`  out  1  in RUN and `byte_cnt` == len-1.
- `frame_done`  out  1  one-cycle pulse after the final bit of a frame.
- `xfer_done`  out  1  one-cycle pulse when the transfer completes.
- `busy`  out  1  state == RUN.
- `err`  out  1  sticky: `bit_inc` was received outside RUN.

## Operation
- States:
  - IDLE: reset/clear state.
  - RUN: counting.
  - HALT: length reached; counters frozen.
- Input priority: `rst` > `clr` > `load` > `bit_inc`.
- `clr` (any state): `bit_cnt`=0, `byte_cnt`=0, `err`=0, state to IDLE. A simultaneous `load` is ignored.
- `load` (any state):
  - Latch `len_in` into internal `len`; `bit_cnt`=0, `byte_cnt`=0, `err`=0.
  - `len_in`≠0: state to RUN.
  - `len_in`=0: state to HALT and `xfer_done` pulses on the next cycle.
  - A simultaneous `bit_inc` is discarded.
- `bit_inc` in RUN:
  - If `bit_cnt` < BITS_PER_FRAME-1: `bit_cnt`+1.
  - Else (frame boundary): `bit_cnt` wraps to 0, `byte_cnt`+1, `frame_done`=1 for one cycle.
  - If that increment makes `byte_cnt` == `len`: `xfer_done`=1 in the same cycle as `frame_done`, and state goes to HALT.
- `bit_inc` in IDLE or HALT: counters unchanged; `err` set to 1 and held until `clr`, `load` or `rst`.
- In HALT, `byte_cnt` == `len` and `bit_cnt`=0 until `clr` or `load`.
- Arithmetic:
  - `byte_cnt` never exceeds `len`, so it cannot wrap, including at `len`=2^LEN_W-1.
  - `bit_cnt` compares against the constant BITS_PER_FRAME-1, truncated to BIT_W bits.
- `ack_slot` and `last_byte` are combinational decodes of registered state. All other outputs are registered.

## Timing
- Reset values: state IDLE, `bit_cnt`=0, `byte_cnt`=0, `len`=0, `frame_done`=0, `xfer_done`=0, `busy`=0, `err`=0, `ack_slot`=0, `last_byte`=0.
- Deasserting `rst` takes effect on the next rising edge; no other reset synchronisation is done in this block.
- `load` at edge N: `busy`=1 after edge N (when `len_in`≠0).
- `bit_inc` at edge N: updated counters visible after edge N (1-cycle latency).
- `frame_done` and `xfer_done` are high for exactly the cycle after the boundary edge. `busy` falls in that same cycle.
- Back-to-back `bit_inc` on every cycle is supported with no lost counts.
- `rst` mid-transfer returns every output to its reset value asynchronously. There is no pending pulse after reset release.

## Test plan
- Reset then `load` `len_in`=2, then 18 consecutive `bit_inc`:
  - `bit_cnt` runs 0..8 twice.
  - `ack_slot` is high at `bit_cnt`=8.
  - `frame_done` pulses after increments 9 and 18.
  - `xfer_done` pulses with the second `frame_done`.
  - Final `byte_cnt`=2, `busy`=0, `err`=0.
- `load` `len_in`=3: `last_byte`=0 for frames 0-1 and `last_byte`=1 during frame 2 (`byte_cnt`=2).
- `load` `len_in`=0: next cycle `xfer_done`=1 and `busy`=0. A following `bit_inc` sets `err`=1 and leaves the counters at 0.
- After 5 `bit_inc` into frame 0, assert `clr` and `load` together: the result is IDLE, counters 0, `busy`=0. A subsequent `load` `len_in`=1 followed by 9 `bit_inc` completes normally.
- Assert `rst` asynchronously mid-frame (`bit_cnt`=4, `byte_cnt`=1): all outputs go to 0 before the next clock edge. `bit_inc` after release sets `err`=1.
- LEN_W=2, BITS_PER_FRAME=2, `load` `len_in`=3, 6 `bit_inc`: `byte_cnt` reaches 3 without wrapping, `xfer_done` pulses once, and a 7th `bit_inc` sets `err`.
